bus_arbiter_rr: RTL and testbench
=================================

// Module: bus_arbiter_rr
// PURPOSE
// Round-robin bus controller for N_MASTERS requesters sharing one address/data path to N_SLAVES slaves.
// Drives master-mux select, one-hot slave select and address/data drive enables.
// Handles OKAY/ERROR/RETRY/SPLIT responses and a wait-state timeout.
// Sits between the master and slave ports of the system bus; generalises the fixed two-master controller.
// PARAMETERS
// N_MASTERS  2   number of masters (2..8); MW = $clog2(N_MASTERS)
// N_SLAVES   2   number of slaves (2..8); SW = $clog2(N_SLAVES)
// MAX_WAIT   15  consecutive ready=0 data cycles allowed before a timeout error (1..255)
// PORTS
// clk        in   1          clock, rising edge
// rst        in   1          asynchronous, active-low reset
// busreq     in   N_MASTERS  per-master level request
// read_write in   1          1=write, 0=read; from granted master, sampled in ADDR
// slv_id     in   SW         target slave of granted master (muxed externally by m_sel), sampled in ADDR
// ready      in   1          slave ready; data phase ends when ready=1
// response   in   2          00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT; valid when ready=1
// split_clr  in   N_MASTERS  slave release; bit i unmasks split master i
// grant      out  N_MASTERS  one-hot grant; all zero when no transfer
// m_sel      out  MW         granted master index, for address/data muxes
// slv_sel    out  N_SLAVES   one-hot slave select
// aout       out  1          address-bus drive enable
// dout       out  1          write-data drive enable
// error      out  1          one-cycle pulse on ERROR, decode error or timeout
// split_mask out  N_MASTERS  masters parked by SPLIT
// BEHAVIOUR
// - Reset (rst=0, async):
//   - state=IDLE; rr pointer=0; wait cnt=0.
//   - grant, m_sel, slv_sel, aout, dout, error and split_mask all 0.
// - All outputs are registered. FSM states: IDLE, ADDR, DATA.
// - IDLE:
//   - elig = busreq & ~split_mask.
//   - elig!=0: pick first set bit at or after the pointer, wrapping; set grant/m_sel to it; go to ADDR.
//   - elig==0: stay in IDLE with grant=0. This includes the case where every master is split-masked.
//   - Latency: busreq seen in IDLE gives grant at the next edge.
// - ADDR (1 cycle):
//   - aout=1; capture read_write and slv_id.
//   - slv_id>=N_SLAVES: error pulse, release bus, go to IDLE, advance pointer.
//   - Otherwise: slv_sel=onehot(slv_id), dout=read_write, go to DATA.
// - DATA:
//   - grant, m_sel, slv_sel, aout and dout are held.
//   - cnt increments on each ready=0 cycle.
//   - ready=1 with OKAY: done.
//   - ready=1 with ERROR: error=1, done.
//   - ready=1 with RETRY: done, pointer NOT advanced, so the same master has top priority next arbitration.
//   - ready=1 with SPLIT: split_mask[m_sel]=1, done.
//   - cnt==MAX_WAIT and ready=0: error=1, done.
// - done:
//   - Clear grant, slv_sel, aout, dout and cnt; return to IDLE.
//   - pointer = (m_sel+1) mod N_MASTERS, except on RETRY.
//   - Minimum of 3 cycles per transfer; IDLE always lasts at least 1 cycle between transfers.
// - busreq dropped mid-transfer is ignored; the transfer completes.
// - split_clr applies in any state. If set and clear of the same bit occur in the same cycle, set wins.
// TESTING
// 1. rst=0 asserted in DATA -> all outputs 0 immediately; after release, busreq=01 -> grant=01 next edge.
// 2. busreq=11 held, ready=1, OKAY every transfer -> grant 01,10,01,10; m_sel 0,1,0,1.
// 3. M0 write, slv_id=1, ready=0 for 3 cycles then OKAY -> slv_sel=10, aout=dout=1 for 4 DATA cycles, then 0.
// 4. SPLIT to M0 with busreq=11 -> split_mask=01, only M1 granted; split_clr=01 -> M0 granted at next arbitration.
// 5. ready held 0, MAX_WAIT=15 -> single error pulse after 15 wait cycles, grant=0 the cycle after.
// 6. RETRY to M1 with busreq=11 -> M1 re-granted; N_MASTERS=4 build, busreq=1010 -> grant 0010,1000 alternating.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus controller: arbitrates N_MASTERS requesters onto one address/data path,
// decodes the target slave and runs the data phase with response handling and a wait timeout.
//
// state | meaning
// IDLE  | bus free, arbitrate among requesting, non-split masters
// ADDR  | address phase, capture read_write and slv_id, decode slave
// DATA  | data phase, wait for ready or timeout, then resolve response
module bus_arbiter_rr #(
   parameter int N_MASTERS = 2,
   parameter int N_SLAVES  = 2,
   parameter int MAX_WAIT  = 15,
   localparam int MW = $clog2(N_MASTERS),
   localparam int SW = $clog2(N_SLAVES),
   localparam int CW = $clog2(MAX_WAIT + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_MASTERS-1:0] busreq,
   input  logic                 read_write,
   input  logic [SW-1:0]        slv_id,
   input  logic                 ready,
   input  logic [1:0]           response,
   input  logic [N_MASTERS-1:0] split_clr,
   output logic [N_MASTERS-1:0] grant,
   output logic [MW-1:0]        m_sel,
   output logic [N_SLAVES-1:0]  slv_sel,
   output logic                 aout,
   output logic                 dout,
   output logic                 error,
   output logic [N_MASTERS-1:0] split_mask
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   localparam logic [1:0] RESP_ERROR = 2'b01;
   localparam logic [1:0] RESP_RETRY = 2'b10;
   localparam logic [1:0] RESP_SPLIT = 2'b11;

   state_t               state, state_nxt;
   logic [MW-1:0]        ptr, ptr_nxt, pick, cand, m_inc, m_sel_nxt;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic [N_MASTERS-1:0] elig, grant_nxt, split_set, split_nxt;
   logic [N_SLAVES-1:0]  slv_sel_nxt;
   logic                 aout_nxt, dout_nxt, error_nxt, done, retry;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         ptr        <= '0;
         cnt        <= '0;
         grant      <= '0;
         m_sel      <= '0;
         slv_sel    <= '0;
         aout       <= 1'b0;
         dout       <= 1'b0;
         error      <= 1'b0;
         split_mask <= '0;
      end else begin
         state      <= state_nxt;
         ptr        <= ptr_nxt;
         cnt        <= cnt_nxt;
         grant      <= grant_nxt;
         m_sel      <= m_sel_nxt;
         slv_sel    <= slv_sel_nxt;
         aout       <= aout_nxt;
         dout       <= dout_nxt;
         error      <= error_nxt;
         split_mask <= split_nxt;
      end
   end

   // Scan from the farthest offset back to the pointer so the nearest eligible master wins.
   always_comb begin
      elig = busreq & ~split_mask;
      pick = ptr;
      cand = ptr;
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
         cand = MW'((int'(ptr) + i) % N_MASTERS);
         if (elig[cand]) pick = cand;
      end
      m_inc = (m_sel == MW'(N_MASTERS - 1)) ? '0 : m_sel + MW'(1);
   end

   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      cnt_nxt     = cnt;
      grant_nxt   = grant;
      m_sel_nxt   = m_sel;
      slv_sel_nxt = slv_sel;
      aout_nxt    = aout;
      dout_nxt    = dout;
      error_nxt   = 1'b0;
      split_set   = '0;
      done        = 1'b0;
      retry       = 1'b0;

      case (state)
         IDLE: begin
            if (|elig) begin
               grant_nxt       = '0;
               grant_nxt[pick] = 1'b1;
               m_sel_nxt       = pick;
               aout_nxt        = 1'b1;
               state_nxt       = ADDR;
            end
         end
         ADDR: begin
            if ({1'b0, slv_id} >= (SW + 1)'(N_SLAVES)) begin
               error_nxt = 1'b1;
               grant_nxt = '0;
               aout_nxt  = 1'b0;
               ptr_nxt   = m_inc;
               state_nxt = IDLE;
            end else begin
               slv_sel_nxt         = '0;
               slv_sel_nxt[slv_id] = 1'b1;
               dout_nxt            = read_write;
               cnt_nxt             = '0;
               state_nxt           = DATA;
            end
         end
         DATA: begin
            if (ready) begin
               done = 1'b1;
               case (response)
                  RESP_ERROR: error_nxt = 1'b1;
                  RESP_RETRY: retry = 1'b1;
                  RESP_SPLIT: split_set[m_sel] = 1'b1;
                  default:    ;
               endcase
            end else if (cnt == CW'(MAX_WAIT)) begin
               error_nxt = 1'b1;
               done      = 1'b1;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
            // A retried master keeps top priority: park the pointer on it rather than past it.
            if (done) begin
               grant_nxt   = '0;
               slv_sel_nxt = '0;
               aout_nxt    = 1'b0;
               dout_nxt    = 1'b0;
               cnt_nxt     = '0;
               ptr_nxt     = retry ? m_sel : m_inc;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      split_nxt = (split_mask & ~split_clr) | split_set;
   end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr (4 masters, 3 slaves): directed scenarios followed by randomized
// transfers, all checked against a transaction-level round-robin model.
module tb_bus_arbiter_rr;
   localparam int NM = 4;
   localparam int NS = 3;
   localparam int MAXW = 15;
   localparam logic [1:0] OKAY = 2'b00, ERR = 2'b01, RETRY = 2'b10, SPLIT = 2'b11;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] busreq = '0, split_clr = '0, grant, split_mask;
   logic       read_write = 1'b0, ready = 1'b0, aout, dout, error;
   logic [1:0] slv_id = '0, response = '0, m_sel;
   logic [2:0] slv_sel;

   int         n_checks = 0, n_pass = 0;
   int         prio = 0;
   logic [3:0] smask = '0;
   logic [3:0] done_clr = '0;

   always #5 clk = ~clk;

   bus_arbiter_rr #(.N_MASTERS(NM), .N_SLAVES(NS), .MAX_WAIT(MAXW)) dut (
      .clk(clk), .rst(rst), .busreq(busreq), .read_write(read_write), .slv_id(slv_id),
      .ready(ready), .response(response), .split_clr(split_clr), .grant(grant),
      .m_sel(m_sel), .slv_sel(slv_sel), .aout(aout), .dout(dout), .error(error),
      .split_mask(split_mask)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic int rr_pick(input logic [3:0] elig, input int from);
      for (int k = 0; k < NM; k++)
         if (((elig >> ((from + k) % NM)) & 4'b1) != 4'b0) return (from + k) % NM;
      return -1;
   endfunction

   function automatic logic [31:0] all_outs();
      return 32'({grant, m_sel, slv_sel, aout, dout, error, split_mask});
   endfunction

   // One complete transfer, entered and left at posedge+1 with the DUT in IDLE.
   task automatic xfer(input logic [3:0] req, input logic rw, input logic [1:0] sid,
                       input int waits, input logic [1:0] resp);
      logic [3:0] elig, clr, set_v;
      int         m, ncyc;
      bit         tmo;
      busreq = req; read_write = rw; slv_id = sid; ready = 1'b0; response = OKAY; split_clr = '0;
      elig = req & ~smask;
      @(posedge clk); #1;
      if (elig == 4'b0) begin
         check("idle_no_grant", 32'(grant), 0);
         return;
      end
      m = rr_pick(elig, prio);
      check("addr_grant", 32'(grant), 32'(1) << m);
      check("addr_msel", 32'(m_sel), 32'(m));
      check("addr_aout_dout", 32'({aout, dout, error}), 32'(3'b100));
      busreq = 4'($urandom);
      @(posedge clk); #1;
      if (sid >= 2'(NS)) begin
         check("decode_err", 32'({grant, aout, error}), 32'(6'b000001));
         prio = (m + 1) % NM;
         check("decode_split", 32'(split_mask), 32'(smask));
         return;
      end
      check("data_slv_sel", 32'(slv_sel), 32'(1) << sid);
      check("data_dout", 32'({aout, dout}), 32'({1'b1, rw}));
      tmo  = waits > MAXW;
      ncyc = tmo ? MAXW + 1 : waits + 1;
      clr  = '0;
      for (int c = 0; c < ncyc; c++) begin
         ready     = !tmo && (c == ncyc - 1);
         response  = ready ? resp : 2'($urandom);
         clr       = (c == ncyc - 1) ? done_clr : 4'b0;
         split_clr = clr;
         @(posedge clk); #1;
         if (c < ncyc - 1)
            check("data_hold", 32'({grant, slv_sel, aout, dout, error}),
                  32'({4'(1 << m), 3'(1 << sid), 1'b1, rw, 1'b0}));
      end
      split_clr = '0; ready = 1'b0;
      set_v = (!tmo && resp == SPLIT) ? 4'(1 << m) : 4'b0;
      smask = (smask & ~clr) | set_v;
      prio  = (!tmo && resp == RETRY) ? m : (m + 1) % NM;
      check("done_release", 32'({grant, slv_sel, aout, dout}), 0);
      check("done_error", 32'(error), 32'(tmo || resp == ERR));
      check("done_split", 32'(split_mask), 32'(smask));
   endtask

   task automatic release_split(input logic [3:0] mask);
      busreq = '0; split_clr = mask;
      @(posedge clk); #1;
      split_clr = '0;
      smask = smask & ~mask;
      check("split_release", 32'(split_mask), 32'(smask));
   endtask

   initial begin
      #12;
      check("reset_outs", all_outs(), 0);
      @(posedge clk); #1;
      rst = 1'b1;

      // asynchronous reset in the middle of a data phase
      busreq = 4'b0001; read_write = 1'b1; slv_id = 2'd0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_reset_data", 32'({aout, dout}), 32'(2'b11));
      rst = 1'b0;
      #1;
      check("async_reset_outs", all_outs(), 0);
      @(posedge clk); #1;
      rst = 1'b1; prio = 0; smask = '0;
      xfer(4'b0001, 1'b0, 2'd0, 0, OKAY);

      repeat (4) xfer(4'b0011, 1'b0, 2'd0, 0, OKAY);
      xfer(4'b0001, 1'b1, 2'd1, 3, OKAY);

      // split with a simultaneous clear of the same bit: the set must win
      xfer(4'b0010, 1'b0, 2'd0, 0, OKAY);
      done_clr = 4'b0001;
      xfer(4'b0011, 1'b0, 2'd2, 1, SPLIT);
      done_clr = 4'b0000;
      xfer(4'b0011, 1'b1, 2'd0, 0, OKAY);
      xfer(4'b0011, 1'b0, 2'd1, 0, OKAY);
      release_split(4'b0001);
      xfer(4'b0011, 1'b0, 2'd0, 0, OKAY);

      // every requester split-masked: bus stays idle
      xfer(4'b0001, 1'b0, 2'd0, 0, SPLIT);
      xfer(4'b0010, 1'b0, 2'd0, 0, SPLIT);
      xfer(4'b0011, 1'b0, 2'd0, 0, OKAY);
      release_split(4'b0011);

      xfer(4'b0001, 1'b0, 2'd2, 20, OKAY);
      xfer(4'b0001, 1'b1, 2'd1, 15, OKAY);
      xfer(4'b0100, 1'b0, 2'd3, 0, OKAY);
      xfer(4'b0011, 1'b0, 2'd0, 0, ERR);
      xfer(4'b0011, 1'b0, 2'd0, 0, RETRY);
      xfer(4'b0011, 1'b0, 2'd0, 0, OKAY);
      repeat (4) xfer(4'b1010, 1'b1, 2'd2, 0, OKAY);

      for (int t = 0; t < 200; t++) begin
         done_clr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
         if ($urandom_range(0, 9) == 0) release_split(4'($urandom));
         xfer(4'($urandom), 1'($urandom),
              ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
              ($urandom_range(0, 9) == 0) ? 16 : $urandom_range(0, 3),
              2'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
